// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between requesters A/B/C, with a registered datapath.
// Latency: grant one cycle after request; memory holds the port via mem_ready; stalled transfers abort after MAX_WAIT cycles.
module mem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [2:0]        i_req,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [ADDR_W-1:0] i_addr_c,
    input  logic [DATA_W-1:0] i_wdata_a,
    input  logic [DATA_W-1:0] i_wdata_b,
    input  logic [DATA_W-1:0] i_wdata_c,
    input  logic              i_we_a,
    input  logic              i_we_b,
    input  logic              i_we_c,
    output logic [2:0]        o_gnt,
    output logic [1:0]        o_sel,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic [2:0]        o_done,
    output logic [2:0]        o_timeout
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_gnt;
    logic [1:0]        r_sel;
    logic [1:0]        r_last;
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_done;
    logic [2:0]        r_timeout;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0]        w_elig;
    logic [1:0]        w_c1;
    logic [1:0]        w_c2;
    logic [1:0]        w_win;
    logic              w_grant;
    logic              w_complete;
    logic              w_abort;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        inc3 = (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        onehot = 3'b001 << i;
    endfunction

    // The requester pulsed done/timeout this cycle is masked so the others get a turn first.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        w_elig      = i_req & ~r_done & ~r_timeout;
        w_c1        = inc3(r_last);
        w_c2        = inc3(w_c1);
        w_win       = r_last;
        if (w_elig[w_c1]) begin
            w_win = w_c1;
        end else if (w_elig[w_c2]) begin
            w_win = w_c2;
        end
        if (r_state == S_IDLE) begin
            if (|w_elig) begin
                w_state_nxt = S_BUSY;
                w_grant     = 1'b1;
            end
        end else begin
            if (i_mem_ready) begin
                w_state_nxt = S_IDLE;
                w_complete  = 1'b1;
            end else if ((MAX_WAIT != 0) && (r_cnt == LIMIT)) begin
                w_state_nxt = S_IDLE;
                w_abort     = 1'b1;
            end
        end
    end

    always_comb begin
        w_addr  = i_addr_a;
        w_wdata = i_wdata_a;
        w_we    = i_we_a;
        case (w_win)
            2'd1: begin
                w_addr  = i_addr_b;
                w_wdata = i_wdata_b;
                w_we    = i_we_b;
            end
            2'd2: begin
                w_addr  = i_addr_c;
                w_wdata = i_wdata_c;
                w_we    = i_we_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_gnt       <= '0;
            r_sel       <= '0;
            r_last      <= 2'd2;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_rdata     <= '0;
            r_done      <= '0;
            r_timeout   <= '0;
            r_cnt       <= '0;
        end else begin
            r_done    <= '0;
            r_timeout <= '0;
            if (w_grant) begin
                r_gnt       <= onehot(w_win);
                r_sel       <= w_win;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                r_mem_we    <= w_we;
                r_cnt       <= '0;
            end else if (w_complete) begin
                r_gnt       <= '0;
                r_mem_valid <= 1'b0;
                r_mem_we    <= 1'b0;
                r_done      <= onehot(r_sel);
                r_last      <= r_sel;
                if (!r_mem_we) begin
                    r_rdata <= i_mem_rdata;
                end
            end else if (w_abort) begin
                r_gnt       <= '0;
                r_mem_valid <= 1'b0;
                r_mem_we    <= 1'b0;
                r_timeout   <= onehot(r_sel);
                r_last      <= r_sel;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we    = r_mem_we;
    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; completion/abort pulses are matched against a queue of expected events.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [31:0] wdata_a, wdata_b, wdata_c;
    logic        we_a, we_b, we_c;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic [2:0]  done;
    logic [2:0]  timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  done;
        logic [2:0]  timeout;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_addr_c(addr_c),
        .i_wdata_a(wdata_a), .i_wdata_b(wdata_b), .i_wdata_c(wdata_c),
        .i_we_a(we_a), .i_we_b(we_b), .i_we_c(we_c),
        .o_gnt(gnt), .o_sel(sel), .o_mem_valid(mem_valid),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_rdata(rdata), .o_done(done), .o_timeout(timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] d, input logic [2:0] t, input logic [31:0] r);
        exp_t e;
        e.done    = d;
        e.timeout = t;
        e.rdata   = r;
        sb_q.push_back(e);
    endtask

    // Advance one clock and sample 1 time unit after the edge; any pulse is matched to the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if ((done | timeout) != 3'b000) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {58'd0, done, timeout}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_done", {61'd0, done}, {61'd0, e.done});
                chk("pulse_timeout", {61'd0, timeout}, {61'd0, e.timeout});
                chk("pulse_rdata", {32'd0, rdata}, {32'd0, e.rdata});
            end
        end
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] idx, input logic [31:0] a, input logic w);
        chk({tag, "_gnt"}, {61'd0, gnt}, {61'd0, 3'b001 << idx});
        chk({tag, "_sel"}, {62'd0, sel}, {62'd0, idx});
        chk({tag, "_valid"}, {63'd0, mem_valid}, 64'd1);
        chk({tag, "_addr"}, {32'd0, mem_addr}, {32'd0, a});
        chk({tag, "_we"}, {63'd0, mem_we}, {63'd0, w});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, {61'd0, gnt}, 64'd0);
        chk({tag, "_valid"}, {63'd0, mem_valid}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rr_idx[4];
        logic [31:0] rr_addr[3];
        logic        rr_we[3];
        rr_idx  = '{2'd0, 2'd1, 2'd2, 2'd0};
        rr_addr = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
        rr_we   = '{1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; req = 3'b111; mem_ready = 1'b0; mem_rdata = 32'h0;
        addr_a = 32'h0; addr_b = 32'h0; addr_c = 32'h0;
        wdata_a = 32'h0; wdata_b = 32'h0; wdata_c = 32'h0;
        we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
        model_rdata = 32'h0;

        // Reset held with all requests active
        step(); step();
        chk_idle("reset");
        chk("reset_sel", {62'd0, sel}, 64'd0);
        chk("reset_we", {63'd0, mem_we}, 64'd0);
        chk("reset_addr", {32'd0, mem_addr}, 64'd0);
        chk("reset_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("reset_rdata", {32'd0, rdata}, 64'd0);
        chk("reset_pulses", {58'd0, done, timeout}, 64'd0);
        rst_n = 1'b1; req = 3'b000;
        step();
        chk_idle("idle_no_req");

        // Single read from A, ready on the fourth busy cycle
        req = 3'b001; addr_a = 32'h0000_0100; we_a = 1'b0;
        step();
        chk_grant("read_a", 2'd0, 32'h0000_0100, 1'b0);
        addr_a = 32'h0000_0BAD;
        step(); step(); step();
        chk_grant("read_a_hold", 2'd0, 32'h0000_0100, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        model_rdata = 32'hDEAD_BEEF;
        push(3'b001, 3'b000, model_rdata);
        step();
        chk("read_a_done", {61'd0, done}, 64'd1);
        chk_idle("read_a_after");
        chk("read_a_sel_kept", {62'd0, sel}, 64'd0);

        // A still requesting in its done cycle: no grant now, grant on the following cycle
        mem_ready = 1'b0;
        step();
        chk_idle("mask");
        step();
        chk_grant("regrant_a", 2'd0, 32'h0000_0BAD, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        model_rdata = 32'h1111_2222;
        push(3'b001, 3'b000, model_rdata);
        step();
        req = 3'b000; mem_ready = 1'b0;
        step();

        // Round robin after reset: A, B(write), C, A
        rst_n = 1'b0;
        step();
        model_rdata = 32'h0;
        rst_n = 1'b1;
        addr_a = rr_addr[0]; addr_b = rr_addr[1]; addr_c = rr_addr[2];
        we_a = rr_we[0]; we_b = rr_we[1]; we_c = rr_we[2];
        wdata_b = 32'hCAFE_0001;
        req = 3'b111; mem_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_grant($sformatf("rr%0d", i), rr_idx[i], rr_addr[rr_idx[i]], rr_we[rr_idx[i]]);
            mem_rdata = 32'hA000_0000 + 32'(i);
            if (!rr_we[rr_idx[i]]) model_rdata = mem_rdata;
            push(3'b001 << rr_idx[i], 3'b000, model_rdata);
            if (i == 1) chk("rr_wdata_b", {32'd0, mem_wdata}, {32'd0, 32'hCAFE_0001});
            step();
            if (i == 3) req = 3'b000;
            step();
        end
        mem_ready = 1'b0;
        chk_idle("rr_end");

        // Timeout on B after four stalled busy cycles
        req = 3'b010; addr_b = 32'h0000_0B0B; we_b = 1'b0;
        step();
        chk_grant("to_b", 2'd1, 32'h0000_0B0B, 1'b0);
        push(3'b000, 3'b010, model_rdata);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_valid", {63'd0, mem_valid}, 64'd1);
            chk("to_wait_pulse", {58'd0, done, timeout}, 64'd0);
        end
        step();
        chk("to_timeout", {61'd0, timeout}, 64'd2);
        chk("to_no_done", {61'd0, done}, 64'd0);
        chk_idle("to_after");
        step();
        chk_idle("to_mask");
        step();
        chk_grant("to_regrant", 2'd1, 32'h0000_0B0B, 1'b0);

        // Ready on the limit cycle: completion wins
        step(); step(); step();
        mem_ready = 1'b1; mem_rdata = 32'h0000_5555;
        model_rdata = 32'h0000_5555;
        push(3'b010, 3'b000, model_rdata);
        step();
        chk("limit_done", {61'd0, done}, 64'd2);
        chk("limit_no_timeout", {61'd0, timeout}, 64'd0);
        req = 3'b000; mem_ready = 1'b0;
        step();

        // Reset in the middle of a C write
        req = 3'b100; addr_c = 32'h0000_0C0C; we_c = 1'b1; wdata_c = 32'h1234_5678;
        step();
        chk_grant("mid_c", 2'd2, 32'h0000_0C0C, 1'b1);
        chk("mid_c_wdata", {32'd0, mem_wdata}, {32'd0, 32'h1234_5678});
        rst_n = 1'b0;
        step();
        chk_idle("mid_rst");
        chk("mid_rst_we", {63'd0, mem_we}, 64'd0);
        chk("mid_rst_pulses", {58'd0, done, timeout}, 64'd0);
        chk("mid_rst_rdata", {32'd0, rdata}, 64'd0);
        rst_n = 1'b1; req = 3'b000;
        step();
        chk("mid_rst_quiet", {58'd0, done, timeout}, 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
